// File: rtl/int_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : int_sequencer
// Purpose  : Prioritised hardware-interrupt sequencer that hijacks opcode
//            fetches and times the vector-entry sequence.
// Revision : 1.0 - initial release
// ============================================================================
module int_sequencer #(
    parameter int                 N_SRC     = 4,
    parameter logic [N_SRC-1:0]   EDGE_MASK = 4'b0001,
    parameter logic [N_SRC-1:0]   NMASK     = 4'b0001,
    parameter int                 ENTRY_LEN = 7,
    localparam int                IDW       = $clog2(N_SRC + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_en,
    input  logic             fetch,
    input  logic             i_flag,
    input  logic [N_SRC-1:0] src,
    output logic             hijack,
    output logic [N_SRC:0]   exe_onehot,
    output logic [IDW-1:0]   exe_id,
    output logic             busy,
    output logic [N_SRC-1:0] pending
);

    localparam logic [0:0]     S_RUN       = 1'b0;
    localparam logic [0:0]     S_ENTRY     = 1'b1;
    localparam logic [3:0]     c_entry_len = 4'(ENTRY_LEN);
    localparam logic [N_SRC:0] c_rst_oh    = {1'b1, {N_SRC{1'b0}}};

    logic [0:0]       r_state;
    logic [3:0]       r_cnt;
    logic [N_SRC:0]   r_exe_onehot;
    logic [IDW-1:0]   r_exe_id;
    logic [N_SRC-1:0] r_src_prev;
    logic [N_SRC-1:0] r_latch;

    logic [N_SRC-1:0] w_edge;
    logic [N_SRC-1:0] w_req;
    logic [N_SRC-1:0] w_pending;
    logic [N_SRC-1:0] w_grant_oh;
    logic [IDW-1:0]   w_grant_id;
    logic [N_SRC-1:0] w_clr;
    logic             w_hijack;

    assign w_edge    = src & ~r_src_prev;
    assign w_req     = (EDGE_MASK & r_latch) | (~EDGE_MASK & src);
    assign w_pending = w_req & (NMASK | {N_SRC{~i_flag}});

    // Walk from the lowest priority upward so the lowest index wins.
    always_comb begin
        w_grant_oh = '0;
        w_grant_id = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (w_pending[k]) begin
                w_grant_oh    = '0;
                w_grant_oh[k] = 1'b1;
                w_grant_id    = IDW'(k);
            end
        end
    end

    assign w_hijack = ~reset & cpu_en & fetch & (r_state == S_RUN) & (|w_pending);
    assign w_clr    = w_hijack ? w_grant_oh : '0;

    // Edge capture runs every clock so pulses during stalled cycles are kept.
    always_ff @(posedge clk) begin
        r_src_prev <= src;
        if (reset) begin
            r_latch <= '0;
        end else begin
            r_latch <= EDGE_MASK & (w_edge | (r_latch & ~w_clr));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_ENTRY;
            r_cnt        <= c_entry_len;
            r_exe_onehot <= c_rst_oh;
            r_exe_id     <= IDW'(N_SRC);
        end else if (cpu_en) begin
            case (r_state)
                S_RUN: begin
                    if (fetch) begin
                        if (w_hijack) begin
                            r_exe_onehot <= {1'b0, w_grant_oh};
                            r_exe_id     <= w_grant_id;
                            r_state      <= S_ENTRY;
                            r_cnt        <= c_entry_len;
                        end else begin
                            r_exe_onehot <= '0;
                            r_exe_id     <= '0;
                        end
                    end
                end
                S_ENTRY: begin
                    if (r_cnt <= 4'd1) begin
                        r_state <= S_RUN;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_ENTRY;
                    r_cnt   <= c_entry_len;
                end
            endcase
        end
    end

    assign hijack     = w_hijack;
    assign exe_onehot = r_exe_onehot;
    assign exe_id     = r_exe_id;
    assign busy       = reset | (r_state == S_ENTRY);
    assign pending    = w_pending;

endmodule
`default_nettype wire

// File: tb/tb_int_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_sequencer
// Purpose  : Directed and random stimulus for int_sequencer against a
//            cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_sequencer;

    localparam int         N   = 4;
    localparam logic [3:0] EM  = 4'b0001;
    localparam logic [3:0] NM  = 4'b0001;
    localparam int         LEN = 7;

    logic       clk = 1'b0;
    logic       reset, cpu_en, fetch, i_flag;
    logic [3:0] src;
    logic       hijack, busy;
    logic [4:0] exe_onehot;
    logic [2:0] exe_id;
    logic [3:0] pending;

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural model: entry cycles left (0 = running), latches, last src.
    int         m_left;
    logic [3:0] m_latch;
    logic [3:0] m_prev;
    logic [4:0] m_onehot;
    int         m_id;

    int_sequencer #(
        .N_SRC     (N),
        .EDGE_MASK (EM),
        .NMASK     (NM),
        .ENTRY_LEN (LEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_en     (cpu_en),
        .fetch      (fetch),
        .i_flag     (i_flag),
        .src        (src),
        .hijack     (hijack),
        .exe_onehot (exe_onehot),
        .exe_id     (exe_id),
        .busy       (busy),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic en, input logic f,
                        input logic fl, input logic [3:0] s);
        logic [3:0] req, pend;
        int         g;
        logic       hij;
        @(negedge clk);
        reset = r; cpu_en = en; fetch = f; i_flag = fl; src = s;
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            req[k]  = EM[k] ? m_latch[k] : s[k];
            pend[k] = req[k] & (NM[k] | ~fl);
        end
        for (int k = N - 1; k >= 0; k--) if (pend[k]) g = k;
        hij = !r && en && f && (m_left == 0) && (g >= 0);
        chk("hijack", hijack, hij);
        chk("busy", busy, r || (m_left > 0));
        chk("pending", pending, pend);
        chk("exe_onehot", exe_onehot, m_onehot);
        chk("exe_id", exe_id, m_id);
        // advance model to the state after the coming clock edge
        for (int k = 0; k < N; k++) begin
            if (r) m_latch[k] = 1'b0;
            else if (EM[k] && s[k] && !m_prev[k]) m_latch[k] = 1'b1;
            else if (hij && g == k) m_latch[k] = 1'b0;
        end
        m_prev = s;
        if (r) begin
            m_left = LEN; m_onehot = 5'b10000; m_id = N;
        end else if (en) begin
            if (m_left == 0) begin
                if (f) begin
                    if (hij) begin
                        m_onehot = 5'(1 << g); m_id = g; m_left = LEN;
                    end else begin
                        m_onehot = '0; m_id = 0;
                    end
                end
            end else begin
                m_left = m_left - 1;
            end
        end
    endtask

    initial begin
        logic [3:0] rs;
        reset = 1'b1; cpu_en = 1'b0; fetch = 1'b0; i_flag = 1'b0; src = 4'b0;
        m_left = LEN; m_latch = '0; m_prev = '0; m_onehot = 5'b10000; m_id = N;
        repeat (2) @(posedge clk);

        // reset release with no sources, then an empty fetch clears the reset id
        step(1, 1, 0, 0, 4'b0000);
        chk("rst_onehot", exe_onehot, 5'b10000);
        chk("rst_id", exe_id, 4);
        repeat (7) step(0, 1, 0, 0, 4'b0000);
        step(0, 1, 1, 0, 4'b0000);
        chk("empty_fetch_hij", hijack, 0);
        step(0, 1, 0, 0, 4'b0000);
        chk("clr_onehot", exe_onehot, 5'b00000);

        // level sources 1 and 2: priority, then drop source 1
        step(0, 1, 1, 0, 4'b0110);
        chk("lvl_hij", hijack, 1);
        step(0, 1, 0, 0, 4'b0110);
        chk("lvl_id1", exe_id, 1);
        repeat (6) step(0, 1, 0, 0, 4'b0110);
        step(0, 1, 1, 0, 4'b0100);
        step(0, 1, 0, 0, 4'b0100);
        chk("lvl_id2", exe_id, 2);
        repeat (6) step(0, 1, 0, 0, 4'b0000);

        // I flag masks source 2 but not the non-maskable edge source 0
        step(0, 1, 0, 1, 4'b0100);
        step(0, 1, 0, 1, 4'b0101);
        step(0, 1, 1, 1, 4'b0100);
        step(0, 1, 0, 1, 4'b0100);
        chk("nmi_onehot", exe_onehot, 5'b00001);
        repeat (6) step(0, 1, 0, 1, 4'b0100);
        step(0, 1, 1, 1, 4'b0100);
        chk("masked_hij", hijack, 0);
        step(0, 1, 1, 0, 4'b0100);
        step(0, 1, 0, 0, 4'b0000);
        chk("unmasked_id", exe_id, 2);
        repeat (6) step(0, 1, 0, 0, 4'b0000);

        // new edge on source 0 in its own acceptance cycle keeps the latch
        step(0, 1, 0, 0, 4'b0001);
        step(0, 1, 0, 0, 4'b0000);
        step(0, 1, 1, 0, 4'b0001);
        step(0, 1, 0, 0, 4'b0001);
        chk("set_wins", pending[0], 1);
        repeat (6) step(0, 1, 0, 0, 4'b0000);
        step(0, 1, 1, 0, 4'b0000);
        chk("rehijack", hijack, 1);
        repeat (7) step(0, 1, 0, 0, 4'b0000);

        // sparse cpu_en during entry; edge captured while cpu_en is low
        step(0, 1, 1, 0, 4'b0100);
        for (int i = 0; i < 7; i++) begin
            step(0, 1, 0, 0, 4'b0100);
            step(0, 0, 0, 0, (i == 2) ? 4'b0101 : 4'b0100);
            step(0, 0, 0, 0, 4'b0100);
        end
        chk("sparse_done", busy, 0);
        step(0, 1, 1, 0, 4'b0100);
        step(0, 1, 0, 0, 4'b0000);
        chk("sparse_id0", exe_id, 0);
        repeat (6) step(0, 1, 0, 0, 4'b0000);

        // reset mid-entry discards source 1, which is re-accepted afterwards
        step(0, 1, 1, 0, 4'b0010);
        repeat (4) step(0, 1, 0, 0, 4'b0010);
        step(1, 1, 0, 0, 4'b0010);
        step(0, 1, 0, 0, 4'b0010);
        chk("midrst_id", exe_id, 4);
        repeat (6) step(0, 1, 0, 0, 4'b0010);
        step(0, 1, 1, 0, 4'b0010);
        step(0, 1, 0, 0, 4'b0010);
        chk("reaccept_id", exe_id, 1);

        // random traffic
        rs = 4'b0000;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) rs = 4'($urandom);
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3), rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
